// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end sharing one bit-serial full adder.
// Operands are summed LSB first, one bit per cycle; the result is offered on a valid/ready port.
module serial_add_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic         busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // reqN_ready is a single-cycle combinational grant in IDLE; res_valid holds in DONE until res_ready.

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  x_sh, y_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          grant0, grant1;
  logic          last_bit;
  logic          ha0_s, ha0_c, ha1_s, ha1_c, carry_nx;

  // Two cascaded half adders; the sum bit of the second is the serial sum bit.
  always_comb begin
    ha0_s    = x_sh[0] ^ y_sh[0];
    ha0_c    = x_sh[0] & y_sh[0];
    ha1_s    = ha0_s ^ carry;
    ha1_c    = ha0_s & carry;
    carry_nx = ha0_c | ha1_c;
  end

  // Contested grants go to the requester that did not win last time.
  assign grant0   = req0_valid & (~req1_valid | last_grant);
  assign grant1   = req1_valid & (~req0_valid | ~last_grant);
  assign last_bit = (cnt == CW'(W - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant0 | grant1) state_nx = RUN;
      RUN:     if (last_bit)        state_nx = DONE;
      DONE:    if (res_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // Gated by rst_n so no grant is ever shown while reset is applied.
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_sh       <= '0;
      y_sh       <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            x_sh       <= grant0 ? req0_x : req1_x;
            y_sh       <= grant0 ? req0_y : req1_y;
            carry      <= 1'b0;
            cnt        <= '0;
            res_id     <= grant1;
            last_grant <= grant1;
          end
        end
        RUN: begin
          x_sh    <= x_sh >> 1;
          y_sh    <= y_sh >> 1;
          carry   <= carry_nx;
          cnt     <= cnt + 1'b1;
          res_sum <= {ha1_s, res_sum[W-1:1]};
          if (last_bit) res_cout <= carry_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: scripted scenarios plus a randomized run against
// an arithmetic/round-robin reference model; a second W=4 instance covers the narrow build.
module tb_serial_add_arbiter;

  localparam int W  = 8;
  localparam int W4 = 4;
  localparam int RW = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic         req0_ready, req1_ready, res_valid, res_cout, res_id, busy;
  logic [W-1:0] res_sum;

  logic          w4_req0_valid = 1'b0, w4_req1_valid = 1'b0, w4_res_ready = 1'b0;
  logic [W4-1:0] w4_req0_x = '0, w4_req0_y = '0, w4_req1_x = '0, w4_req1_y = '0;
  logic          w4_req0_ready, w4_req1_ready, w4_res_valid, w4_res_cout, w4_res_id, w4_busy;
  logic [W4-1:0] w4_res_sum;

  int             checks = 0;
  int             errors = 0;
  bit             model_last = 1'b1;
  logic [RW-1:0]  exp_q[$];

  always #5 clk = ~clk;

  serial_add_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  serial_add_arbiter #(.W(W4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w4_req0_valid), .req0_x(w4_req0_x), .req0_y(w4_req0_y), .req0_ready(w4_req0_ready),
    .req1_valid(w4_req1_valid), .req1_x(w4_req1_x), .req1_y(w4_req1_y), .req1_ready(w4_req1_ready),
    .res_valid(w4_res_valid), .res_ready(w4_res_ready), .res_sum(w4_res_sum),
    .res_cout(w4_res_cout), .res_id(w4_res_id), .busy(w4_busy)
  );

  // Reference: {id, carry-out, sum} from a plain (W+1)-bit addition.
  function automatic logic [RW-1:0] model_add(input bit id, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] f;
    f = {1'b0, x} + {1'b0, y};
    return {id, f};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    w4_req0_valid = 1'b0; w4_req1_valid = 1'b0; w4_res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready, res_valid, busy, res_cout, res_id} !== 6'b0 || res_sum !== '0) begin
      errors++;
      $display("FAIL reset_state: r1,r0,rv,busy,cout,id=%b sum=%h expected all zero",
               {req1_ready, req0_ready, res_valid, busy, res_cout, res_id}, res_sum);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single(input bit who, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [RW-1:0] exp;
    int lat;
    exp = model_add(who, x, y);
    do_reset();
    if (who) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else     begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== (who ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL single_grant(%0d): ready r1r0=%b expected %b", who, {req1_ready, req0_ready}, who ? 2'b10 : 2'b01);
    end
    @(negedge clk); #1;
    checks++;
    if ({req1_ready, req0_ready, busy} !== 3'b001) begin
      errors++;
      $display("FAIL single_pulse(%0d): r1,r0,busy=%b expected 001", who, {req1_ready, req0_ready, busy});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 4 * W) begin
      @(negedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL single_latency(%0d): res_valid after %0d cycles expected %0d", who, lat, W + 1);
    end
    checks++;
    if ({res_id, res_cout, res_sum} !== exp) begin
      errors++;
      $display("FAIL single_result(%0d): id,cout,sum=%h expected %h", who, {res_id, res_cout, res_sum}, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_retire(%0d): rv,busy=%b expected 00", who, {res_valid, busy});
    end
  endtask

  task automatic test_contention();
    int rets, cyc;
    bit exp_who, new0, new1;
    logic [RW-1:0] got;
    do_reset();
    exp_q.delete();
    req0_x = 8'h80; req0_y = 8'h80;
    req1_x = W'($urandom); req1_y = W'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    rets = 0; cyc = 0; exp_who = 1'b0; new0 = 1'b0; new1 = 1'b0;
    while (rets < 4 && cyc < 20 * W) begin
      if (new0) begin req0_x = W'($urandom); req0_y = W'($urandom); new0 = 1'b0; end
      if (new1) begin req1_x = W'($urandom); req1_y = W'($urandom); new1 = 1'b0; end
      #1;
      if (res_valid === 1'b1) begin
        got = {res_id, res_cout, res_sum};
        checks++;
        if (exp_q.size() == 0 || got !== exp_q[0]) begin
          errors++;
          $display("FAIL contention_result %0d: id,cout,sum=%h expected %h", rets, got,
                   exp_q.size() ? exp_q[0] : '0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rets++;
      end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        checks++;
        if ({req1_ready, req0_ready} !== (exp_who ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL contention_grant: r1r0=%b expected %b", {req1_ready, req0_ready}, exp_who ? 2'b10 : 2'b01);
        end
        if (req1_ready === 1'b1) begin exp_q.push_back(model_add(1'b1, req1_x, req1_y)); new1 = 1'b1; end
        else                     begin exp_q.push_back(model_add(1'b0, req0_x, req0_y)); new0 = 1'b1; end
        exp_who = ~exp_who;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rets != 4) begin
      errors++;
      $display("FAIL contention_timeout: %0d results in %0d cycles expected 4", rets, cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] exp;
    int wait_cyc;
    do_reset();
    req0_valid = 1'b1; req0_x = W'($urandom); req0_y = W'($urandom);
    exp = model_add(1'b0, req0_x, req0_y);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_cyc = 0;
    while (res_valid !== 1'b1 && wait_cyc < 4 * W) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
      req0_x = W'($urandom); req1_x = W'($urandom);
      #1;
      checks++;
      if ({res_valid, req1_ready, req0_ready} !== 3'b100 || {res_id, res_cout, res_sum} !== exp) begin
        errors++;
        $display("FAIL backpressure_hold %0d: rv,r1,r0=%b result=%h expected 100 / %h",
                 i, {res_valid, req1_ready, req0_ready}, {res_id, res_cout, res_sum}, exp);
      end
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    checks++;
    if ({res_valid, req1_ready, req0_ready} !== 3'b100) begin
      errors++;
      $display("FAIL backpressure_retire: rv,r1,r0=%b expected 100", {res_valid, req1_ready, req0_ready});
    end
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    checks++;
    if ({res_valid, req1_ready, req0_ready} !== 3'b010) begin
      errors++;
      $display("FAIL backpressure_next_accept: rv,r1,r0=%b expected 010", {res_valid, req1_ready, req0_ready});
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req0_valid = 1'b1; req0_x = '1; req0_y = '0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: req0_ready=%b expected 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready, res_valid, busy, res_cout, res_id} !== 6'b0 || res_sum !== '0) begin
      errors++;
      $display("FAIL midrst_state: r1,r0,rv,busy,cout,id=%b sum=%h expected all zero",
               {req1_ready, req0_ready, res_valid, busy, res_cout, res_id}, res_sum);
    end
    repeat (W + 2) @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result: res_valid=%b expected 0", res_valid);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_first_grant: r1r0=%b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random(input int n);
    bit pend, new0, new1, w0, w1, e0, e1, erv;
    int gcyc;
    logic [RW-1:0] got;
    do_reset();
    exp_q.delete();
    pend = 1'b0; new0 = 1'b1; new1 = 1'b1; gcyc = 0;
    for (int t = 0; t < n; t++) begin
      if (new0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0); req0_x = W'($urandom); req0_y = W'($urandom); new0 = 1'b0;
      end else if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
      if (new1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0); req1_x = W'($urandom); req1_y = W'($urandom); new1 = 1'b0;
      end else if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      w0  = req0_valid && (!req1_valid || model_last);
      w1  = req1_valid && (!req0_valid || !model_last);
      e0  = !pend && w0;
      e1  = !pend && w1;
      erv = pend && (t >= gcyc + W + 1);
      checks++;
      if ({req1_ready, req0_ready, res_valid, busy} !== {e1, e0, erv, pend}) begin
        errors++;
        $display("FAIL rand_ctrl t=%0d: r1,r0,rv,busy=%b expected %b", t,
                 {req1_ready, req0_ready, res_valid, busy}, {e1, e0, erv, pend});
      end
      if (erv) begin
        got = {res_id, res_cout, res_sum};
        checks++;
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_result t=%0d: id,cout,sum=%h expected %h", t, got, exp_q[0]);
        end
        if (res_ready) begin void'(exp_q.pop_front()); pend = 1'b0; end
      end
      if (e0) begin
        exp_q.push_back(model_add(1'b0, req0_x, req0_y)); pend = 1'b1; gcyc = t; model_last = 1'b0; new0 = 1'b1;
      end else if (e1) begin
        exp_q.push_back(model_add(1'b1, req1_x, req1_y)); pend = 1'b1; gcyc = t; model_last = 1'b1; new1 = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_w4();
    logic [W4:0] f;
    int lat;
    do_reset();
    w4_req0_valid = 1'b1; w4_req0_x = 4'hF; w4_req0_y = 4'hF;
    f = {1'b0, w4_req0_x} + {1'b0, w4_req0_y};
    #1;
    checks++;
    if (w4_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL w4_grant: req0_ready=%b expected 1", w4_req0_ready);
    end
    @(negedge clk);
    w4_req0_valid = 1'b0;
    #1;
    lat = 1;
    while (w4_res_valid !== 1'b1 && lat < 4 * W4) begin
      @(negedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != W4 + 1) begin
      errors++;
      $display("FAIL w4_latency: res_valid after %0d cycles expected %0d", lat, W4 + 1);
    end
    checks++;
    if ({w4_res_id, w4_res_cout, w4_res_sum} !== {1'b0, f}) begin
      errors++;
      $display("FAIL w4_result: id,cout,sum=%h expected %h", {w4_res_id, w4_res_cout, w4_res_sum}, {1'b0, f});
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 8'hA5, 8'h5A);
    test_single(1'b1, 8'hFF, 8'h01);
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_random(800);
    test_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
